// File: rtl/jtframe_dwnld_prog.sv
// ---------------------------------------------------------------------------
// jtframe_dwnld_prog
//
// Turns byte-wide ROM download writes into SDRAM programming requests.
// The file header is stripped, the image is split into four SDRAM banks,
// and bytes are buffered in a small FIFO so that SDRAM back-pressure does
// not lose data. Each request is held until the controller accepts it,
// followed by a one-cycle gap.
//
// Optional feature macro: JTFRAME_DWNLD_SWAB_EN
//   defined   -> odd bytes go to the low lane (mask 2'b10), even bytes to
//                the high lane (mask 2'b01), for byte-swapped images.
//   undefined -> even byte to low lane (2'b10), odd byte to high lane (2'b01).
//
// Ports:
//   clk          single clock (ROM download domain)
//   rst          synchronous reset, active-high
//   downloading  ROM download in progress
//   ioctl_addr   byte address of the download byte (25 bits)
//   ioctl_data   download byte
//   ioctl_rom_wr one-cycle strobe, address/data valid
//   prog_addr    SDRAM word address within the bank (22 bits)
//   prog_data    byte to write
//   prog_mask    byte-lane mask, active-low, bit0 = low lane
//   prog_bank    SDRAM bank
//   prog_we      write request, held until accepted
//   prog_rdy     controller accepts the request when prog_we=1
//   dwnld_busy   download or SDRAM programming still in progress
//   overflow     sticky, a byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module jtframe_dwnld_prog #(
  parameter logic [24:0] HEADER    = 25'd0,
  parameter logic [24:0] BA1_START = 25'h100000,
  parameter logic [24:0] BA2_START = 25'h200000,
  parameter logic [24:0] BA3_START = 25'h300000,
  parameter int          FIFO_AW   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_rom_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [1:0]  bank;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Active-low lane mask for a byte, honouring the optional byte swap.
  function automatic logic [1:0] lane_mask(input logic odd);
`ifdef JTFRAME_DWNLD_SWAB_EN
    lane_mask = odd ? 2'b10 : 2'b01;
`else
    lane_mask = odd ? 2'b01 : 2'b10;
`endif
  endfunction

  // FIFO storage and pointers
  entry_t             r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  // Output stage
  state_t      r_state;
  logic        r_we;
  logic [21:0] r_addr;
  logic [7:0]  r_data;
  logic [1:0]  r_mask;
  logic [1:0]  r_bank;
  logic        r_busy;
  logic        r_overflow;

  // Push-side address arithmetic
  logic        w_accept;
  logic [24:0] w_a;
  logic [1:0]  w_bank;
  logic [22:0] w_start;
  logic [22:0] w_off;
  entry_t      w_new;
  entry_t      w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  assign w_accept = ioctl_rom_wr & downloading & (ioctl_addr >= HEADER);
  assign w_a      = ioctl_addr - HEADER;

  // Bank select and bank start offset (only the low 23 bits of the offset matter).
  always_comb begin
    w_bank  = 2'd0;
    w_start = 23'd0;
    if (w_a >= BA3_START) begin
      w_bank  = 2'd3;
      w_start = BA3_START[22:0];
    end else if (w_a >= BA2_START) begin
      w_bank  = 2'd2;
      w_start = BA2_START[22:0];
    end else if (w_a >= BA1_START) begin
      w_bank  = 2'd1;
      w_start = BA1_START[22:0];
    end else begin
      w_bank  = 2'd0;
      w_start = 23'd0;
    end
  end

  // Offset within the bank wraps at 8 MB, so modulo-2^23 subtraction suffices.
  assign w_off      = w_a[22:0] - w_start;
  assign w_new.addr = w_off[22:1];
  assign w_new.mask = lane_mask(w_off[0]);
  assign w_new.bank = w_bank;
  assign w_new.data = ioctl_data;

  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_count == {(FIFO_AW + 1){1'b0}});
  assign w_full  = (r_count == CNT_MAX);
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = w_accept & (~w_full | w_pop);
  assign w_drop  = w_accept & w_full & ~w_pop;

  // FIFO data array; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {FIFO_AW{1'b0}};
      r_rd_ptr <= {FIFO_AW{1'b0}};
      r_count  <= {(FIFO_AW + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Request state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= 22'd0;
      r_data  <= 8'd0;
      r_mask  <= 2'b11;
      r_bank  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_addr  <= w_head.addr;
            r_mask  <= w_head.mask;
            r_bank  <= w_head.bank;
            r_data  <= w_head.data;
            r_we    <= 1'b1;
            r_state <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (prog_rdy) begin
            r_we    <= 1'b0;
            r_state <= S_GAP;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Busy flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_busy <= downloading | ~w_empty | (r_state != S_IDLE);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign prog_addr  = r_addr;
  assign prog_data  = r_data;
  assign prog_mask  = r_mask;
  assign prog_bank  = r_bank;
  assign prog_we    = r_we;
  assign dwnld_busy = r_busy;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_jtframe_dwnld_prog.sv
// ---------------------------------------------------------------------------
// tb_jtframe_dwnld_prog
//
// Directed bench. dut0 uses HEADER=0, dut1 uses HEADER=64; they share the
// ioctl bus but have separate downloading/prog_rdy so only one accepts at a
// time. A monitor records accepted requests, prog_we rise edges and
// dwnld_busy fall edges for dut0.
// ---------------------------------------------------------------------------
module tb_jtframe_dwnld_prog;

  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  mask;
    logic [1:0]  bank;
    logic [7:0]  data;
  } req_t;

`ifdef JTFRAME_DWNLD_SWAB_EN
  localparam logic [1:0] M_EVEN = 2'b01;
  localparam logic [1:0] M_ODD  = 2'b10;
`else
  localparam logic [1:0] M_EVEN = 2'b10;
  localparam logic [1:0] M_ODD  = 2'b01;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dl0 = 1'b0;
  logic        dl1 = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic        ioctl_rom_wr = 1'b0;
  logic        rdy0 = 1'b0;
  logic        rdy1 = 1'b0;

  logic [21:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic [1:0]  mask0, mask1, bank0, bank1;
  logic        we0, we1, busy0, busy1, ovf0, ovf1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jtframe_dwnld_prog #(.HEADER(25'd0), .FIFO_AW(2)) dut0 (
    .clk(clk), .rst(rst), .downloading(dl0),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_rom_wr(ioctl_rom_wr),
    .prog_addr(addr0), .prog_data(data0), .prog_mask(mask0), .prog_bank(bank0),
    .prog_we(we0), .prog_rdy(rdy0), .dwnld_busy(busy0), .overflow(ovf0)
  );

  jtframe_dwnld_prog #(.HEADER(25'd64), .FIFO_AW(2)) dut1 (
    .clk(clk), .rst(rst), .downloading(dl1),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_rom_wr(ioctl_rom_wr),
    .prog_addr(addr1), .prog_data(data1), .prog_mask(mask1), .prog_bank(bank1),
    .prog_we(we1), .prog_rdy(rdy1), .dwnld_busy(busy1), .overflow(ovf1)
  );

  // Monitor: cyc = number of posedges so far; edge indices below follow it.
  int   cyc = 0;
  logic we0_q = 1'b0;
  logic busy0_q = 1'b0;
  req_t acc0 [$];
  int   acc_e0 [$];
  int   rise0 [$];
  int   fall0 [$];
  int   n_acc1 = 0;
  req_t last1 = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    we0_q   <= we0;
    busy0_q <= busy0;
    if (we0 && !we0_q) rise0.push_back(cyc);
    if (busy0_q && !busy0) fall0.push_back(cyc);
    if (we0 && rdy0) begin
      acc0.push_back(req_t'{addr0, mask0, bank0, data0});
      acc_e0.push_back(cyc + 1);
    end
    if (we1 && rdy1) begin
      n_acc1 <= n_acc1 + 1;
      last1  <= req_t'{addr1, mask1, bank1, data1};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe, sampled at the next posedge.
  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_rom_wr = 1'b1;
    ioctl_addr   = a;
    ioctl_data   = d;
    @(posedge clk);
    #1;
    ioctl_rom_wr = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_cmp++; if (we0 !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", we0); end
    n_cmp++; if (addr0 !== 22'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr0); end
    n_cmp++; if (data0 !== 8'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data0); end
    n_cmp++; if (mask0 !== 2'b11) begin n_bad++; $display("FAIL reset_mask: got %b want 11", mask0); end
    n_cmp++; if (bank0 !== 2'd0) begin n_bad++; $display("FAIL reset_bank: got %d want 0", bank0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic;
    int b, r, t0;
    do_reset();
    b = acc0.size(); r = rise0.size();
    dl0 = 1'b1; rdy0 = 1'b1;
    t0 = cyc;
    strobe(25'd0, 8'hA5);
    strobe(25'd1, 8'h5A);
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy0); end
    dl0 = 1'b0;
    tick(15);
    n_cmp++; if (acc0.size() - b !== 2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", acc0.size() - b); end
    n_cmp++; if (acc0[b] !== req_t'{22'd0, M_EVEN, 2'd0, 8'hA5}) begin n_bad++; $display("FAIL basic_req0: got %h want %h", acc0[b], req_t'{22'd0, M_EVEN, 2'd0, 8'hA5}); end
    n_cmp++; if (acc0[b+1] !== req_t'{22'd0, M_ODD, 2'd0, 8'h5A}) begin n_bad++; $display("FAIL basic_req1: got %h want %h", acc0[b+1], req_t'{22'd0, M_ODD, 2'd0, 8'h5A}); end
    n_cmp++; if (rise0[r] !== t0 + 2) begin n_bad++; $display("FAIL basic_latency: got edge %0d want %0d", rise0[r], t0 + 2); end
    n_cmp++; if (rise0[r+1] - rise0[r] !== 3) begin n_bad++; $display("FAIL basic_spacing: got %0d want 3", rise0[r+1] - rise0[r]); end
  endtask

  task automatic test_header;
    int b0, b1;
    do_reset();
    b0 = acc0.size(); b1 = n_acc1;
    dl0 = 1'b0; dl1 = 1'b1; rdy1 = 1'b1; rdy0 = 1'b1;
    for (int i = 0; i < 64; i++) strobe(25'(i), 8'(i));
    tick(5);
    n_cmp++; if (n_acc1 - b1 !== 0) begin n_bad++; $display("FAIL header_skip: got %0d requests want 0", n_acc1 - b1); end
    strobe(25'd64, 8'h3C);
    tick(6);
    n_cmp++; if (n_acc1 - b1 !== 1) begin n_bad++; $display("FAIL header_count: got %0d want 1", n_acc1 - b1); end
    n_cmp++; if (last1 !== req_t'{22'd0, M_EVEN, 2'd0, 8'h3C}) begin n_bad++; $display("FAIL header_req: got %h want %h", last1, req_t'{22'd0, M_EVEN, 2'd0, 8'h3C}); end
    n_cmp++; if (acc0.size() - b0 !== 0) begin n_bad++; $display("FAIL ignored_strobes: got %0d want 0", acc0.size() - b0); end
    dl1 = 1'b0; rdy1 = 1'b0;
  endtask

  task automatic test_banks;
    int b;
    req_t exp_q [5];
    exp_q[0] = req_t'{22'h1,     M_ODD,  2'd2, 8'hC3};
    exp_q[1] = req_t'{22'h7FFFF, M_ODD,  2'd0, 8'h3C};
    exp_q[2] = req_t'{22'h0,     M_EVEN, 2'd1, 8'h11};
    exp_q[3] = req_t'{22'h7FFFF, M_EVEN, 2'd3, 8'h22};
    exp_q[4] = req_t'{22'h27FFFF, M_ODD, 2'd3, 8'h33};
    do_reset();
    b = acc0.size();
    dl0 = 1'b1; rdy0 = 1'b1;
    strobe(25'h200003, 8'hC3);
    strobe(25'h0FFFFF, 8'h3C);
    strobe(25'h100000, 8'h11);
    strobe(25'h3FFFFE, 8'h22);
    strobe(25'h1FFFFFF, 8'h33);
    dl0 = 1'b0;
    tick(25);
    n_cmp++; if (acc0.size() - b !== 5) begin n_bad++; $display("FAIL banks_count: got %0d want 5", acc0.size() - b); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (acc0[b+i] !== exp_q[i]) begin n_bad++; $display("FAIL banks_req%0d: got %h want %h", i, acc0[b+i], exp_q[i]); end
    end
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL banks_ovf: got %b want 0", ovf0); end
  endtask

  task automatic test_overflow;
    int b;
    do_reset();
    b = acc0.size();
    dl0 = 1'b1; rdy0 = 1'b0;
    for (int i = 0; i < 5; i++) strobe(25'(i), 8'h10 + 8'(i));
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", ovf0); end
    strobe(25'd5, 8'h15);
    n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf0); end
    dl0 = 1'b0;
    tick(2);
    rdy0 = 1'b1;
    tick(25);
    n_cmp++; if (acc0.size() - b !== 5) begin n_bad++; $display("FAIL ovf_count: got %0d want 5", acc0.size() - b); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (acc0[b+i] !== req_t'{22'(i / 2), ((i % 2) != 0) ? M_ODD : M_EVEN, 2'd0, 8'h10 + 8'(i)}) begin
        n_bad++;
        $display("FAIL ovf_req%0d: got %h want %h", i, acc0[b+i], req_t'{22'(i / 2), ((i % 2) != 0) ? M_ODD : M_EVEN, 2'd0, 8'h10 + 8'(i)});
      end
    end
    n_cmp++; if (ovf0 !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf0); end
    do_reset();
    n_cmp++; if (ovf0 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
  endtask

  task automatic test_reset_mid;
    int b;
    do_reset();
    b = acc0.size();
    dl0 = 1'b1; rdy0 = 1'b0;
    strobe(25'd20, 8'h77);
    strobe(25'd21, 8'h78);
    tick(1);
    n_cmp++; if (we0 !== 1'b1) begin n_bad++; $display("FAIL mid_we_before: got %b want 1", we0); end
    rst = 1'b1; dl0 = 1'b0;
    tick(1);
    n_cmp++; if (we0 !== 1'b0) begin n_bad++; $display("FAIL mid_we_after: got %b want 0", we0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy0); end
    rst = 1'b0; rdy0 = 1'b1;
    tick(15);
    n_cmp++; if (acc0.size() - b !== 0) begin n_bad++; $display("FAIL mid_no_req: got %0d want 0", acc0.size() - b); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL mid_busy_idle: got %b want 0", busy0); end
  endtask

  task automatic test_drain;
    int b, r, f;
    do_reset();
    b = acc0.size(); r = rise0.size(); f = fall0.size();
    dl0 = 1'b1; rdy0 = 1'b0;
    for (int i = 0; i < 4; i++) strobe(25'd8 + 25'(i), 8'h20 + 8'(i));
    dl0 = 1'b0;
    tick(3);
    n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL drain_busy_held: got %b want 1", busy0); end
    rdy0 = 1'b1;
    tick(25);
    n_cmp++; if (acc0.size() - b !== 4) begin n_bad++; $display("FAIL drain_count: got %0d want 4", acc0.size() - b); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (acc0[b+i] !== req_t'{22'(4 + i / 2), ((i % 2) != 0) ? M_ODD : M_EVEN, 2'd0, 8'h20 + 8'(i)}) begin
        n_bad++;
        $display("FAIL drain_req%0d: got %h want %h", i, acc0[b+i], req_t'{22'(4 + i / 2), ((i % 2) != 0) ? M_ODD : M_EVEN, 2'd0, 8'h20 + 8'(i)});
      end
    end
    n_cmp++; if (rise0[r+3] - rise0[r+2] !== 3) begin n_bad++; $display("FAIL drain_spacing: got %0d want 3", rise0[r+3] - rise0[r+2]); end
    n_cmp++; if (fall0.size() - f !== 1) begin n_bad++; $display("FAIL drain_fall_count: got %0d want 1", fall0.size() - f); end
    n_cmp++; if (fall0[f] !== acc_e0[b+3] + 2) begin n_bad++; $display("FAIL drain_busy_fall: got edge %0d want %0d", fall0[f], acc_e0[b+3] + 2); end
    rdy0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_header();
    test_banks();
    test_overflow();
    test_reset_mid();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
